// File: rtl/lfsr_victim_sel_if.sv
// Request/grant bundle between a cache miss handler, the victim selector and
// the refill datapath. Signal names keep the selector's port naming.
interface lfsr_victim_sel_if #(
  parameter int unsigned LFSR_WIDTH = 16,
  parameter int unsigned NUM_WAYS   = 8
);
  localparam int unsigned WAY_W = $clog2(NUM_WAYS);

  logic                  req_i;
  logic [NUM_WAYS-1:0]   way_mask_i;
  logic                  seed_load_i;
  logic [LFSR_WIDTH-1:0] seed_i;
  logic                  ready_i;
  logic                  valid_o;
  logic [NUM_WAYS-1:0]   way_oh_o;
  logic [WAY_W-1:0]      way_bin_o;
  logic                  no_way_o;

  // Requester/consumer side
  modport master (
    output req_i, way_mask_i, seed_load_i, seed_i, ready_i,
    input  valid_o, way_oh_o, way_bin_o, no_way_o
  );

  // Selector side
  modport slave (
    input  req_i, way_mask_i, seed_load_i, seed_i, ready_i,
    output valid_o, way_oh_o, way_bin_o, no_way_o
  );
endinterface

// File: rtl/lfsr_victim_sel.sv
// Pseudo-random victim/way selector: an XNOR LFSR picks a candidate way, a
// rotating search skips ineligible ways, and the result is offered on a
// valid/ready handshake.
// Optional macro LFSR_VICTIM_SEL_FREERUN_EN: LFSR steps every cycle instead of
// once per accepted grant.
module lfsr_victim_sel #(
  parameter int unsigned           LFSR_WIDTH = 16,
  parameter int unsigned           NUM_WAYS   = 8,
  parameter logic [LFSR_WIDTH-1:0] SEED       = '0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  lfsr_victim_sel_if.slave   bus
);

  localparam int unsigned WAY_W = $clog2(NUM_WAYS);
  localparam int unsigned IDX_W = WAY_W + 1;

  // Tap masks, bit n-1 set for 1-based tap n
  localparam logic [31:0] TAPS32 =
    (LFSR_WIDTH == 8)  ? 32'h0000_00B8 :
    (LFSR_WIDTH == 12) ? 32'h0000_0829 :
    (LFSR_WIDTH == 16) ? 32'h0000_D008 :
    (LFSR_WIDTH == 24) ? 32'h00E1_0000 :
                         32'h8020_0003;
  localparam logic [LFSR_WIDTH-1:0] TAPS = LFSR_WIDTH'(TAPS32);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_VALID = 1'b1;

  // Reject unsupported parameterisations at elaboration
  if (!(LFSR_WIDTH == 8 || LFSR_WIDTH == 12 || LFSR_WIDTH == 16 ||
        LFSR_WIDTH == 24 || LFSR_WIDTH == 32)) begin : g_bad_lfsr_width
    $error("lfsr_victim_sel: LFSR_WIDTH must be 8, 12, 16, 24 or 32");
  end
  if (NUM_WAYS < 2 || NUM_WAYS > 32) begin : g_bad_num_ways
    $error("lfsr_victim_sel: NUM_WAYS must be in 2..32");
  end

  logic [0:0]            state_q,   state_d;
  logic [LFSR_WIDTH-1:0] lfsr_q,    lfsr_d;
  logic                  valid_q,   valid_d;
  logic [NUM_WAYS-1:0]   way_oh_q,  way_oh_d;
  logic [WAY_W-1:0]      way_bin_q, way_bin_d;
  logic                  no_way_q,  no_way_d;

  logic [WAY_W-1:0]      cand_raw_c;
  logic [WAY_W-1:0]      cand_c;
  logic [IDX_W-1:0]      idx_c;
  logic [WAY_W-1:0]      sel_bin_c;
  logic                  sel_found_c;
  logic [LFSR_WIDTH-1:0] lfsr_step_c;
  logic [LFSR_WIDTH-1:0] seed_fix_c;
  logic                  advance_c;

  // Next LFSR value and lockup-safe reseed value
  always_comb begin
    lfsr_step_c = {lfsr_q[LFSR_WIDTH-2:0], ~^(lfsr_q & TAPS)};
    seed_fix_c  = bus.seed_i;
    if (&bus.seed_i) begin
      seed_fix_c[0] = 1'b0;
    end
  end

  // Candidate way from the low LFSR bits, folded once into range
  always_comb begin
    cand_raw_c = lfsr_q[WAY_W-1:0];
    cand_c     = cand_raw_c;
    if (IDX_W'(cand_raw_c) >= IDX_W'(NUM_WAYS)) begin
      cand_c = WAY_W'(IDX_W'(cand_raw_c) - IDX_W'(NUM_WAYS));
    end
  end

  // Rotating search: first eligible way at or above the candidate, wrapping to 0
  always_comb begin
    sel_bin_c   = '0;
    sel_found_c = 1'b0;
    idx_c       = '0;
    for (int unsigned i = 0; i < NUM_WAYS; i++) begin
      idx_c = IDX_W'(cand_c) + IDX_W'(i);
      if (idx_c >= IDX_W'(NUM_WAYS)) begin
        idx_c = idx_c - IDX_W'(NUM_WAYS);
      end
      if (!sel_found_c && bus.way_mask_i[idx_c[WAY_W-1:0]]) begin
        sel_found_c = 1'b1;
        sel_bin_c   = idx_c[WAY_W-1:0];
      end
    end
  end

  // Next-state, output and LFSR update logic
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    way_oh_d  = way_oh_q;
    way_bin_d = way_bin_q;
    no_way_d  = 1'b0;
    lfsr_d    = lfsr_q;
`ifdef LFSR_VICTIM_SEL_FREERUN_EN
    advance_c = 1'b1;
`else
    advance_c = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.req_i) begin
          if (sel_found_c) begin
            state_d   = ST_VALID;
            valid_d   = 1'b1;
            way_bin_d = sel_bin_c;
            way_oh_d  = NUM_WAYS'(1) << sel_bin_c;
          end else begin
            no_way_d = 1'b1;
          end
        end
      end
      ST_VALID: begin
        if (bus.ready_i) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
`ifdef LFSR_VICTIM_SEL_FREERUN_EN
`else
          advance_c = 1'b1;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase

    // Reseed wins over a step in the same cycle
    if (bus.seed_load_i) begin
      lfsr_d = seed_fix_c;
    end else if (advance_c) begin
      lfsr_d = lfsr_step_c;
    end
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= SEED;
      valid_q   <= 1'b0;
      way_oh_q  <= '0;
      way_bin_q <= '0;
      no_way_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      valid_q   <= valid_d;
      way_oh_q  <= way_oh_d;
      way_bin_q <= way_bin_d;
      no_way_q  <= no_way_d;
    end
  end

  assign bus.valid_o   = valid_q;
  assign bus.way_oh_o  = way_oh_q;
  assign bus.way_bin_o = way_bin_q;
  assign bus.no_way_o  = no_way_q;

endmodule

// File: tb/tb_lfsr_victim_sel.sv
// Bench for lfsr_victim_sel: directed scenarios plus randomized traffic
// checked against an arithmetic model of the LFSR and way search.
module tb_lfsr_victim_sel;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  lfsr_victim_sel_if #(.LFSR_WIDTH(8), .NUM_WAYS(8)) b8 ();
  lfsr_victim_sel_if #(.LFSR_WIDTH(8), .NUM_WAYS(5)) b5 ();

  lfsr_victim_sel #(.LFSR_WIDTH(8), .NUM_WAYS(8), .SEED(8'h00)) u_dut8 (
    .clk_i (clk), .rst_ni (rst_n), .bus (b8)
  );
  lfsr_victim_sel #(.LFSR_WIDTH(8), .NUM_WAYS(5), .SEED(8'h00)) u_dut5 (
    .clk_i (clk), .rst_ni (rst_n), .bus (b5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: one LFSR step, taps 8,6,5,4, XNOR feedback into bit 0
  function automatic int unsigned m_step(input int unsigned l);
    int unsigned par;
    par = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
    return ((l << 1) & 32'hFF) | (1 - par);
  endfunction

  // Reference: reseed value with all-ones replaced
  function automatic int unsigned m_fix(input int unsigned s);
    return (s == 32'hFF) ? 32'hFE : s;
  endfunction

  // Reference: first eligible way from the folded candidate (n if none)
  function automatic int unsigned m_pick(input int unsigned l, input int unsigned mask,
                                         input int unsigned n);
    int unsigned c;
    int unsigned w;
    c = l % 8;
    if (c >= n) c = c - n;
    for (int unsigned k = 0; k < n; k++) begin
      w = (c + k) % n;
      if (((mask >> w) & 1) == 1) return w;
    end
    return n;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Present one request on the 8-way unit and sample its outputs a cycle later
  task automatic req8(input logic [7:0] m, output logic v, output logic [2:0] b,
                      output logic [7:0] oh, output logic nw);
    @(negedge clk);
    b8.seed_load_i = 1'b0;
    b8.req_i       = 1'b1;
    b8.way_mask_i  = m;
    @(negedge clk);
    b8.req_i = 1'b0;
    v  = b8.valid_o;
    b  = b8.way_bin_o;
    oh = b8.way_oh_o;
    nw = b8.no_way_o;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (b8.valid_o !== 1'b0) $display("FAIL reset_valid8: got %b exp 0", b8.valid_o); else n_pass++;
    n_checks++; if (b8.way_oh_o !== 8'h00) $display("FAIL reset_oh8: got %h exp 00", b8.way_oh_o); else n_pass++;
    n_checks++; if (b8.way_bin_o !== 3'd0) $display("FAIL reset_bin8: got %0d exp 0", b8.way_bin_o); else n_pass++;
    n_checks++; if (b8.no_way_o !== 1'b0) $display("FAIL reset_noway8: got %b exp 0", b8.no_way_o); else n_pass++;
    n_checks++; if (b5.valid_o !== 1'b0) $display("FAIL reset_valid5: got %b exp 0", b5.valid_o); else n_pass++;
    n_checks++; if (b5.way_oh_o !== 5'h00) $display("FAIL reset_oh5: got %h exp 00", b5.way_oh_o); else n_pass++;
    n_checks++; if (b5.way_bin_o !== 3'd0) $display("FAIL reset_bin5: got %0d exp 0", b5.way_bin_o); else n_pass++;
    n_checks++; if (b5.no_way_o !== 1'b0) $display("FAIL reset_noway5: got %b exp 0", b5.no_way_o); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic_sequence();
    logic [2:0] eb [4];
    logic [7:0] eo [4];
    logic v, nw;
    logic [2:0] b;
    logic [7:0] oh;
    eb = '{3'd0, 3'd1, 3'd3, 3'd7};
    eo = '{8'h01, 8'h02, 8'h08, 8'h80};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req8(8'hFF, v, b, oh, nw);
      n_checks++; if (v !== 1'b1) $display("FAIL basic_valid[%0d]: got %b exp 1", i, v); else n_pass++;
      n_checks++; if (b !== eb[i]) $display("FAIL basic_bin[%0d]: got %0d exp %0d", i, b, eb[i]); else n_pass++;
      n_checks++; if (oh !== eo[i]) $display("FAIL basic_oh[%0d]: got %h exp %h", i, oh, eo[i]); else n_pass++;
      @(negedge clk);
      n_checks++; if (b8.valid_o !== 1'b0) $display("FAIL basic_drop[%0d]: got %b exp 0", i, b8.valid_o); else n_pass++;
    end
  endtask

  task automatic test_masked_way();
    logic v, nw;
    logic [2:0] b;
    logic [7:0] oh;
    do_reset();
    req8(8'hFF, v, b, oh, nw); @(negedge clk);
    req8(8'hFF, v, b, oh, nw); @(negedge clk);
    req8(8'hF7, v, b, oh, nw);
    n_checks++; if (b !== 3'd4) $display("FAIL masked_skip_bin: got %0d exp 4", b); else n_pass++;
    n_checks++; if (oh !== 8'h10) $display("FAIL masked_skip_oh: got %h exp 10", oh); else n_pass++;
    @(negedge clk);
    req8(8'h07, v, b, oh, nw);
    n_checks++; if (b !== 3'd0) $display("FAIL masked_wrap_bin: got %0d exp 0", b); else n_pass++;
    n_checks++; if (oh !== 8'h01) $display("FAIL masked_wrap_oh: got %h exp 01", oh); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_non_pow2();
    int unsigned m5;
    int unsigned e;
    logic [4:0] mask;
    do_reset();
    @(negedge clk);
    b5.seed_load_i = 1'b1;
    b5.seed_i      = 8'h07;
    @(negedge clk);
    b5.seed_load_i = 1'b0;
    b5.req_i       = 1'b1;
    b5.way_mask_i  = 5'h1F;
    @(negedge clk);
    b5.req_i = 1'b0;
    n_checks++; if (b5.valid_o !== 1'b1) $display("FAIL np2_valid: got %b exp 1", b5.valid_o); else n_pass++;
    n_checks++; if (b5.way_bin_o !== 3'd2) $display("FAIL np2_bin: got %0d exp 2", b5.way_bin_o); else n_pass++;
    n_checks++; if (b5.way_oh_o !== 5'h04) $display("FAIL np2_oh: got %h exp 04", b5.way_oh_o); else n_pass++;
    @(negedge clk);
    m5 = m_step(32'h07);
    for (int i = 0; i < 24; i++) begin
      mask = 5'($urandom_range(1, 31));
      e = m_pick(m5, 32'(mask), 5);
      b5.req_i      = 1'b1;
      b5.way_mask_i = mask;
      @(negedge clk);
      b5.req_i = 1'b0;
      n_checks++; if (b5.way_bin_o !== 3'(e)) $display("FAIL np2_rand_bin[%0d]: got %0d exp %0d mask %h", i, b5.way_bin_o, e, mask); else n_pass++;
      n_checks++; if (b5.way_oh_o !== 5'(1 << e)) $display("FAIL np2_rand_oh[%0d]: got %h exp %h", i, b5.way_oh_o, 5'(1 << e)); else n_pass++;
      @(negedge clk);
      m5 = m_step(m5);
    end
  endtask

  task automatic test_empty_mask();
    logic v, nw;
    logic [2:0] b;
    logic [7:0] oh;
    int unsigned e;
    do_reset();
    req8(8'h00, v, b, oh, nw);
    n_checks++; if (nw !== 1'b1) $display("FAIL empty_noway: got %b exp 1", nw); else n_pass++;
    n_checks++; if (v !== 1'b0) $display("FAIL empty_valid: got %b exp 0", v); else n_pass++;
    @(negedge clk);
    n_checks++; if (b8.no_way_o !== 1'b0) $display("FAIL empty_pulse_len: got %b exp 0", b8.no_way_o); else n_pass++;
    e = m_pick(0, 32'hFF, 8);
    req8(8'hFF, v, b, oh, nw);
    n_checks++; if (b !== 3'(e)) $display("FAIL empty_after_bin: got %0d exp %0d", b, e); else n_pass++;
    n_checks++; if (nw !== 1'b0) $display("FAIL empty_after_noway: got %b exp 0", nw); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_lockup_stall();
    logic v, nw;
    logic [2:0] b;
    logic [7:0] oh;
    int unsigned e;
    do_reset();
    @(negedge clk);
    b8.seed_load_i = 1'b1;
    b8.seed_i      = 8'hFF;
    b8.ready_i     = 1'b0;
    req8(8'hFF, v, b, oh, nw);
    n_checks++; if (b !== 3'd6) $display("FAIL lockup_bin: got %0d exp 6", b); else n_pass++;
    n_checks++; if (oh !== 8'h40) $display("FAIL lockup_oh: got %h exp 40", oh); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      b8.req_i = (i % 2 == 0);
      @(negedge clk);
      n_checks++; if (b8.valid_o !== 1'b1) $display("FAIL stall_valid[%0d]: got %b exp 1", i, b8.valid_o); else n_pass++;
      n_checks++; if (b8.way_bin_o !== 3'd6) $display("FAIL stall_bin[%0d]: got %0d exp 6", i, b8.way_bin_o); else n_pass++;
    end
    b8.req_i   = 1'b0;
    b8.ready_i = 1'b1;
    @(negedge clk);
    n_checks++; if (b8.valid_o !== 1'b0) $display("FAIL stall_release: got %b exp 0", b8.valid_o); else n_pass++;
    e = m_pick(m_step(32'hFE), 32'hFF, 8);
    req8(8'hFF, v, b, oh, nw);
    n_checks++; if (b !== 3'(e)) $display("FAIL lockup_next_bin: got %0d exp %0d", b, e); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic v, nw;
    logic [2:0] b;
    logic [7:0] oh;
    do_reset();
    req8(8'hFF, v, b, oh, nw); @(negedge clk);
    b8.ready_i = 1'b0;
    req8(8'hFF, v, b, oh, nw);
    n_checks++; if (v !== 1'b1) $display("FAIL rstmid_pre_valid: got %b exp 1", v); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (b8.valid_o !== 1'b0) $display("FAIL rstmid_valid: got %b exp 0", b8.valid_o); else n_pass++;
    n_checks++; if (b8.way_oh_o !== 8'h00) $display("FAIL rstmid_oh: got %h exp 00", b8.way_oh_o); else n_pass++;
    n_checks++; if (b8.way_bin_o !== 3'd0) $display("FAIL rstmid_bin: got %0d exp 0", b8.way_bin_o); else n_pass++;
    b8.ready_i = 1'b1;
    req8(8'hFE, v, b, oh, nw);
    n_checks++; if (b !== 3'd1) $display("FAIL rstmid_seed_bin: got %0d exp 1", b); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_random();
    int unsigned m8;
    int unsigned e;
    int unsigned holds;
    logic [7:0] mask, s;
    logic v, nw, sl;
    logic [2:0] b;
    logic [7:0] oh;
    do_reset();
    m8 = 0;
    for (int it = 0; it < 150; it++) begin
      b8.ready_i = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        s = 8'($urandom);
        @(negedge clk);
        b8.seed_load_i = 1'b1;
        b8.seed_i      = s;
        m8 = m_fix(32'(s));
      end
      mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      req8(mask, v, b, oh, nw);
      e = m_pick(m8, 32'(mask), 8);
      if (mask == 8'h00) begin
        n_checks++; if (nw !== 1'b1) $display("FAIL rand_noway[%0d]: got %b exp 1", it, nw); else n_pass++;
        n_checks++; if (v !== 1'b0) $display("FAIL rand_novalid[%0d]: got %b exp 0", it, v); else n_pass++;
      end else begin
        n_checks++; if (v !== 1'b1) $display("FAIL rand_valid[%0d]: got %b exp 1", it, v); else n_pass++;
        n_checks++; if (b !== 3'(e)) $display("FAIL rand_bin[%0d]: got %0d exp %0d lfsr %h mask %h", it, b, e, m8, mask); else n_pass++;
        n_checks++; if (oh !== 8'(1 << e)) $display("FAIL rand_oh[%0d]: got %h exp %h", it, oh, 8'(1 << e)); else n_pass++;
        holds = $urandom_range(0, 3);
        for (int h = 0; h < int'(holds); h++) begin
          if ($urandom_range(0, 2) == 0) begin
            s = 8'($urandom);
            b8.seed_load_i = 1'b1;
            b8.seed_i      = s;
            m8 = m_fix(32'(s));
          end
          @(negedge clk);
          b8.seed_load_i = 1'b0;
          n_checks++; if (b8.valid_o !== 1'b1) $display("FAIL rand_hold_valid[%0d]: got %b exp 1", it, b8.valid_o); else n_pass++;
          n_checks++; if (b8.way_bin_o !== 3'(e)) $display("FAIL rand_hold_bin[%0d]: got %0d exp %0d", it, b8.way_bin_o, e); else n_pass++;
        end
        sl = ($urandom_range(0, 3) == 0);
        s  = 8'($urandom);
        b8.ready_i = 1'b1;
        if (sl) begin
          b8.seed_load_i = 1'b1;
          b8.seed_i      = s;
        end
        @(negedge clk);
        b8.ready_i     = 1'b0;
        b8.seed_load_i = 1'b0;
        n_checks++; if (b8.valid_o !== 1'b0) $display("FAIL rand_ack[%0d]: got %b exp 0", it, b8.valid_o); else n_pass++;
        m8 = sl ? m_fix(32'(s)) : m_step(m8);
      end
    end
    b8.ready_i = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    b8.req_i = 1'b0; b8.way_mask_i = '0; b8.seed_load_i = 1'b0; b8.seed_i = '0; b8.ready_i = 1'b1;
    b5.req_i = 1'b0; b5.way_mask_i = '0; b5.seed_load_i = 1'b0; b5.seed_i = '0; b5.ready_i = 1'b1;
    test_reset();
    test_basic_sequence();
    test_masked_way();
    test_non_pow2();
    test_empty_mask();
    test_lockup_stall();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lfsr_victim_sel.md
# lfsr_victim_sel

Pseudo-random victim/way selector for set-associative caches and multi-bank buffers. A configurable-width XNOR LFSR supplies the selection. It supports any way count, including non-powers of two, and skips ineligible (locked/invalid) ways through a rotating search. The selected way is presented on a valid/ready handshake. It sits between the cache miss handler (requester) and the refill datapath (consumer).

## Interface
- `LFSR_WIDTH`, 16: LFSR length; legal values 8, 12, 16, 24, 32; any other value is an elaboration error.
- `NUM_WAYS`, 8: number of selectable ways, 2..32.
- `SEED`, all-zero: reset value of the LFSR.
- `clk_i` input 1: clock.
- `rst_ni` input 1: reset, synchronous, active-low.
- `req_i` input 1: request a victim; sampled only in IDLE.
- `way_mask_i` input NUM_WAYS: eligible ways (1 = selectable); sampled with `req_i`.
- `seed_load_i` input 1: load `seed_i` into the LFSR.
- `seed_i` input LFSR_WIDTH: reseed value.
- `valid_o` output 1: selection available.
- `ready_i` input 1: consumer accepts the selection.
- `way_oh_o` output NUM_WAYS: one-hot selected way.
- `way_bin_o` output $clog2(NUM_WAYS): binary selected way.
- `no_way_o` output 1: one-cycle pulse when a request found no eligible way.

## Operation
- **LFSR**
  - Left shift with XNOR feedback: `shift_in = ~^(taps)`. The new bit enters at bit 0.
  - Taps (1-based): 8→{8,6,5,4}; 12→{12,6,4,1}; 16→{16,15,13,4}; 24→{24,23,22,17}; 32→{32,22,2,1}.
  - All-ones is the lockup state. If `seed_i` is all-ones, it is loaded with bit 0 cleared.
- **Candidate**
  - `c` = LFSR bits [$clog2(NUM_WAYS)-1:0].
  - If `c >= NUM_WAYS`, then `c = c - NUM_WAYS`.
- **Search**
  - The selected way is the first set bit of the sampled mask, scanning from `c` upward with wrap to 0. If `way_mask_i[c]` is set, the selected way is `c`.
  - The search is fully combinational within the request cycle.
- **FSM states**
  - IDLE:
    - `req_i` with mask ≠ 0 → register the way and go to VALID.
    - `req_i` with mask = 0 → pulse `no_way_o`, stay in IDLE, LFSR does not advance.
  - VALID:
    - `valid_o` = 1; `way_oh_o` and `way_bin_o` are held stable.
    - On `valid_o & ready_i` → go to IDLE and advance the LFSR by one step.
- `req_i` in VALID is ignored. The requester holds it until the handshake and re-presents it afterwards.
- **Seed load**
  - Allowed in any state.
  - Takes priority over an LFSR advance in the same cycle.
  - Does not change a pending `way_*_o` selection.
- **Reset values:** state IDLE, LFSR = SEED, `valid_o` = 0, `way_oh_o` = 0, `way_bin_o` = 0, `no_way_o` = 0.

## Timing
- Request to `valid_o`: 1 cycle. `req_i` is sampled at edge N and `valid_o` is high after edge N.
- `no_way_o` is high for exactly the cycle after the failing request edge.
- Handshake at edge M: `valid_o` is low after M. The earliest next request is sampled at M+1, so throughput is one grant per 2 cycles.
- The advanced LFSR value is used by the next accepted request.
- Reset asserted in VALID: all outputs return to reset values after the next edge, regardless of `ready_i`.
- `seed_load_i` at edge K: the loaded value is the candidate source for a request sampled at edge K+1 or later.

## Configuration
- `LFSR_VICTIM_SEL_FREERUN_EN` defined:
  - The LFSR advances every cycle, except when `seed_load_i` is high.
  - Handshake does not add an extra step.
  - This decorrelates selection from the request pattern.
- Undefined (default): the LFSR advances only on a `valid_o & ready_i` handshake, so the sequence is deterministic per grant.

## Test plan
- **Basic sequence.** LFSR_WIDTH=8, NUM_WAYS=8, SEED=0x00, FREERUN off, mask=0xFF, `ready_i` tied high. Four requests, each after the previous handshake → `way_bin_o` = 0, 1, 3, 7; `way_oh_o` = 0x01, 0x02, 0x08, 0x80.
- **Masked way.** After two grants (LFSR=0x03), request with mask=0xF7 → `way_bin_o`=4. Then with mask=0x07 at LFSR=0x07 → wraps to `way_bin_o`=0.
- **Non-power-of-two ways.** NUM_WAYS=5, seed load 0x07, request with mask=0x1F → candidate 7−5 gives `way_bin_o`=2, `way_oh_o`=0x04.
- **Empty mask.** Request with mask=0x00 → `no_way_o` high for 1 cycle, `valid_o` stays 0, LFSR unchanged. The next request with mask=0xFF returns the same way as it would have.
- **Lockup guard and stall.** Seed load 0xFF → LFSR holds 0xFE, so the next grant is way 6. Hold `ready_i`=0 for 5 cycles → `valid_o` and the way stay constant.
- **Reset mid-operation.** Drop `rst_ni` for 1 cycle while in VALID with `ready_i`=0 → `valid_o`=0 and `way_oh_o`=0 next cycle, LFSR=SEED.
